// File: rtl/tbus_arbiter_pkg.sv
// ============================================================================
//  Module      : tbus_arbiter_pkg
//  Description : Owner and FSM state encodings shared by the tbus arbiter and
//                its starvation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TBUS_DEFINES_SV
`include "defines.sv"
`endif

package tbus_arbiter_pkg;

    // Which requester currently owns the dcache tbus.
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_LOAD  = 2'd1,
        OWNER_STORE = 2'd2
    } owner_e;

    // Arbiter FSM: IDLE offers a grant, BUSY waits for operation_done.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Wide enough for the largest legal starvation limit (255).
    localparam int STARVE_CTR_W = 8;

endpackage

`default_nettype wire

// File: rtl/defines.sv
// ============================================================================
//  File        : defines.sv
//  Description : Shared tbus field ranges used by the tbus arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef TBUS_DEFINES_SV
`define TBUS_DEFINES_SV

`define RESULT_RANGE      63:0
`define SRC_RANGE         63:0
`define TBUS_OPTYPE_RANGE 1:0

`endif

// File: rtl/tbus_starve_ctr.sv
// ============================================================================
//  Module      : tbus_starve_ctr
//  Description : Saturating counter of consecutive store-side losses. Counts
//                up on i_inc, clears on i_clr (clear wins), and flags o_sat
//                once the count reaches LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbus_starve_ctr
    import tbus_arbiter_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [STARVE_CTR_W-1:0] c_LIMIT = STARVE_CTR_W'(LIMIT);
    localparam logic [STARVE_CTR_W-1:0] c_ONE   = STARVE_CTR_W'(1);

    logic [STARVE_CTR_W-1:0] r_count;

    // Count losses, hold at the limit, drop to zero when the store wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_sat = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/tbus_arbiter.sv
// ============================================================================
//  Module      : tbus_arbiter
//  Description : Two-requester arbiter (load pipe, store queue) in front of a
//                single dcache tbus. Load has priority; one operation is in
//                flight at a time, with a one-cycle bubble after each done.
//                Optional store anti-starvation is enabled by defining the
//                macro TBUS_ARB_STARVE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TBUS_DEFINES_SV
`include "defines.sv"
`endif

module tbus_arbiter
    import tbus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,

    // Load pipe requester
    input  logic                      lsu2arb_tbus_index_valid,
    output logic                      lsu2arb_tbus_index_ready,
    input  logic [`RESULT_RANGE]      lsu2arb_tbus_index,
    input  logic [`SRC_RANGE]         lsu2arb_tbus_write_data,
    input  logic [63:0]               lsu2arb_tbus_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE] lsu2arb_tbus_operation_type,
    output logic [`RESULT_RANGE]      lsu2arb_tbus_read_data,
    output logic                      lsu2arb_tbus_operation_done,

    // Store queue requester
    input  logic                      sq2arb_tbus_index_valid,
    output logic                      sq2arb_tbus_index_ready,
    input  logic [`RESULT_RANGE]      sq2arb_tbus_index,
    input  logic [`SRC_RANGE]         sq2arb_tbus_write_data,
    input  logic [63:0]               sq2arb_tbus_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE] sq2arb_tbus_operation_type,
    output logic [`RESULT_RANGE]      sq2arb_tbus_read_data,
    output logic                      sq2arb_tbus_operation_done,

    // Dcache side
    output logic                      arb2dcache_tbus_index_valid,
    input  logic                      arb2dcache_tbus_index_ready,
    output logic [`RESULT_RANGE]      arb2dcache_tbus_index,
    output logic [`SRC_RANGE]         arb2dcache_tbus_write_data,
    output logic [63:0]               arb2dcache_tbus_write_mask,
    output logic [`TBUS_OPTYPE_RANGE] arb2dcache_tbus_operation_type,
    input  logic [`RESULT_RANGE]      arb2dcache_tbus_read_data,
    input  logic                      arb2dcache_tbus_operation_done
);

    state_e r_state;
    state_e w_state_nxt;
    owner_e r_owner;
    owner_e w_owner_nxt;
    owner_e w_winner;

    logic   w_force_store;
    logic   w_arb_valid;
    logic   w_lsu_ready;
    logic   w_sq_ready;
    logic   w_lsu_done;
    logic   w_sq_done;

`ifdef TBUS_ARB_STARVE_EN
    logic   w_starve_inc;
    logic   w_starve_sat;

    // A store that keeps losing while IDLE accumulates; a store grant clears.
    assign w_starve_inc = (r_state == ST_IDLE) && sq2arb_tbus_index_valid && !w_sq_ready;

    tbus_starve_ctr #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_starve_inc),
        .i_clr   (w_sq_ready),
        .o_sat   (w_starve_sat)
    );

    assign w_force_store = w_starve_sat && sq2arb_tbus_index_valid;
`else
    logic [7:0] w_unused_limit;

    // Strict load priority: the limit has no effect in this build.
    assign w_unused_limit = 8'(STARVE_LIMIT);
    assign w_force_store  = 1'b0;
`endif

    // Pick the requester that would win if a grant were offered this cycle.
    always_comb begin
        w_winner = OWNER_NONE;
        if (lsu2arb_tbus_index_valid && !w_force_store) begin
            w_winner = OWNER_LOAD;
        end else if (sq2arb_tbus_index_valid) begin
            w_winner = OWNER_STORE;
        end
    end

    // Payload follows the store only when it wins; otherwise the load payload
    // is driven so the bus never floats to X.
    assign arb2dcache_tbus_index          = (w_winner == OWNER_STORE) ? sq2arb_tbus_index          : lsu2arb_tbus_index;
    assign arb2dcache_tbus_write_data     = (w_winner == OWNER_STORE) ? sq2arb_tbus_write_data     : lsu2arb_tbus_write_data;
    assign arb2dcache_tbus_write_mask     = (w_winner == OWNER_STORE) ? sq2arb_tbus_write_mask     : lsu2arb_tbus_write_mask;
    assign arb2dcache_tbus_operation_type = (w_winner == OWNER_STORE) ? sq2arb_tbus_operation_type : lsu2arb_tbus_operation_type;

    // State and owner registers; reset abandons any in-flight operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= OWNER_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state and handshake outputs; reset_n gates every strobe so nothing
    // leaks out while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_arb_valid = 1'b0;
        w_lsu_ready = 1'b0;
        w_sq_ready  = 1'b0;
        w_lsu_done  = 1'b0;
        w_sq_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_valid = reset_n && (w_winner != OWNER_NONE);
                w_lsu_ready = reset_n && (w_winner == OWNER_LOAD)  && arb2dcache_tbus_index_ready;
                w_sq_ready  = reset_n && (w_winner == OWNER_STORE) && arb2dcache_tbus_index_ready;
                if (w_arb_valid && arb2dcache_tbus_index_ready) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_winner;
                end
            end
            ST_BUSY: begin
                w_lsu_done = reset_n && (r_owner == OWNER_LOAD)  && arb2dcache_tbus_operation_done;
                w_sq_done  = reset_n && (r_owner == OWNER_STORE) && arb2dcache_tbus_operation_done;
                if (arb2dcache_tbus_operation_done) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWNER_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWNER_NONE;
            end
        endcase
    end

    assign arb2dcache_tbus_index_valid = w_arb_valid;
    assign lsu2arb_tbus_index_ready    = w_lsu_ready;
    assign sq2arb_tbus_index_ready     = w_sq_ready;
    assign lsu2arb_tbus_operation_done = w_lsu_done;
    assign sq2arb_tbus_operation_done  = w_sq_done;

    // Read data is a plain broadcast; only the done strobe is steered.
    assign lsu2arb_tbus_read_data = arb2dcache_tbus_read_data;
    assign sq2arb_tbus_read_data  = arb2dcache_tbus_read_data;

endmodule

`default_nettype wire

// File: tb/tb_tbus_arbiter.sv
// ============================================================================
//  Module      : tb_tbus_arbiter
//  Description : Self-checking bench for tbus_arbiter. Expected grant indices
//                are queued as requests are driven and popped by a monitor on
//                every dcache fire; handshake/done routing checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tbus_arbiter;

`ifdef TBUS_ARB_STARVE_EN
    localparam bit c_STARVE = 1'b1;
`else
    localparam bit c_STARVE = 1'b0;
`endif
    localparam int c_LIMIT = 2;

    logic        clock;
    logic        reset_n;
    logic        lsu_valid, lsu_ready, lsu_done;
    logic [63:0] lsu_index, lsu_wdata, lsu_wmask, lsu_rdata;
    logic [1:0]  lsu_op;
    logic        sq_valid, sq_ready, sq_done;
    logic [63:0] sq_index, sq_wdata, sq_wmask, sq_rdata;
    logic [1:0]  sq_op;
    logic        arb_valid, arb_ready, dc_done;
    logic [63:0] arb_index, arb_wdata, arb_wmask, dc_rdata;
    logic [1:0]  arb_op;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];

    tbus_arbiter #(
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .lsu2arb_tbus_index_valid       (lsu_valid),
        .lsu2arb_tbus_index_ready       (lsu_ready),
        .lsu2arb_tbus_index             (lsu_index),
        .lsu2arb_tbus_write_data        (lsu_wdata),
        .lsu2arb_tbus_write_mask        (lsu_wmask),
        .lsu2arb_tbus_operation_type    (lsu_op),
        .lsu2arb_tbus_read_data         (lsu_rdata),
        .lsu2arb_tbus_operation_done    (lsu_done),
        .sq2arb_tbus_index_valid        (sq_valid),
        .sq2arb_tbus_index_ready        (sq_ready),
        .sq2arb_tbus_index              (sq_index),
        .sq2arb_tbus_write_data         (sq_wdata),
        .sq2arb_tbus_write_mask         (sq_wmask),
        .sq2arb_tbus_operation_type     (sq_op),
        .sq2arb_tbus_read_data          (sq_rdata),
        .sq2arb_tbus_operation_done     (sq_done),
        .arb2dcache_tbus_index_valid    (arb_valid),
        .arb2dcache_tbus_index_ready    (arb_ready),
        .arb2dcache_tbus_index          (arb_index),
        .arb2dcache_tbus_write_data     (arb_wdata),
        .arb2dcache_tbus_write_mask     (arb_wmask),
        .arb2dcache_tbus_operation_type (arb_op),
        .arb2dcache_tbus_read_data      (dc_rdata),
        .arb2dcache_tbus_operation_done (dc_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Every dcache fire must match the oldest expected grant.
    always @(negedge clock) begin
        if (reset_n && arb_valid && arb_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("grant_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("grant_index", arb_index, exp_q.pop_front());
            end
        end
    end

    initial begin
        int ctr;
        bit st;

        reset_n   = 1'b0;
        lsu_valid = 1'b1;
        sq_valid  = 1'b0;
        arb_ready = 1'b1;
        dc_done   = 1'b0;
        dc_rdata  = 64'h0;
        lsu_index = 64'h1111; lsu_wdata = 64'hA0A0; lsu_wmask = 64'hFF; lsu_op = 2'd1;
        sq_index  = 64'h2222; sq_wdata  = 64'hB0B0; sq_wmask  = 64'hF0; sq_op  = 2'd2;

        // Outputs quiet while reset is held, even with a request present
        #2;
        check_eq("rst_arb_valid", arb_valid, 0);
        check_eq("rst_lsu_ready", lsu_ready, 0);
        check_eq("rst_sq_ready",  sq_ready,  0);
        check_eq("rst_lsu_done",  lsu_done,  0);
        check_eq("rst_sq_done",   sq_done,   0);
        step(); step();
        lsu_valid = 1'b0;
        reset_n   = 1'b1;

        // Idle, no requests: done ignored, load payload on the bus, read data broadcast
        dc_done = 1'b1; dc_rdata = 64'h55;
        #1;
        check_eq("idle_arb_valid",  arb_valid, 0);
        check_eq("idle_payload",    arb_index, 64'h1111);
        check_eq("idle_lsu_done",   lsu_done,  0);
        check_eq("idle_sq_done",    sq_done,   0);
        check_eq("idle_rdata_bcast", lsu_rdata, 64'h55);
        step();
        dc_done = 1'b0;

        // Simultaneous requests: load wins
        lsu_valid = 1'b1; sq_valid = 1'b1;
        exp_q.push_back(64'h1111);
        #1;
        check_eq("both_lsu_ready", lsu_ready, 1);
        check_eq("both_sq_ready",  sq_ready,  0);
        check_eq("both_arb_index", arb_index, 64'h1111);
        check_eq("both_arb_wdata", arb_wdata, 64'hA0A0);
        check_eq("both_arb_op",    arb_op,    2'd1);
        step();
        lsu_valid = 1'b0;
        #1;
        check_eq("busy_arb_valid", arb_valid, 0);
        check_eq("busy_sq_ready",  sq_ready,  0);
        dc_done = 1'b1; dc_rdata = 64'hBEEF;
        #1;
        check_eq("load_done_lsu", lsu_done, 1);
        check_eq("load_done_sq",  sq_done,  0);
        step();
        dc_done = 1'b0;

        // Held-off store is granted once idle again
        exp_q.push_back(64'h2222);
        #1;
        check_eq("store_sq_ready",  sq_ready,  1);
        check_eq("store_arb_wdata", arb_wdata, 64'hB0B0);
        check_eq("store_arb_wmask", arb_wmask, 64'hF0);
        check_eq("store_arb_op",    arb_op,    2'd2);
        step();
        sq_valid = 1'b0;
        step(); step();
        // Third cycle after the grant: done with 0xDEAD, new load request waiting
        dc_done = 1'b1; dc_rdata = 64'hDEAD; lsu_valid = 1'b1;
        #1;
        check_eq("store_done_sq",    sq_done,   1);
        check_eq("store_done_lsu",   lsu_done,  0);
        check_eq("store_rdata_lsu",  lsu_rdata, 64'hDEAD);
        check_eq("store_rdata_sq",   sq_rdata,  64'hDEAD);
        check_eq("bubble_arb_valid", arb_valid, 0);
        check_eq("bubble_lsu_ready", lsu_ready, 0);
        step();
        dc_done = 1'b0;
        exp_q.push_back(64'h1111);
        #1;
        check_eq("after_bubble_lsu_ready", lsu_ready, 1);
        step();
        lsu_valid = 1'b0;
        dc_done   = 1'b1;
        step();
        dc_done = 1'b0;

        // Dcache back-pressure: request held, no ready, stays idle
        lsu_valid = 1'b1; arb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("stall_arb_valid", arb_valid, 1);
            check_eq("stall_lsu_ready", lsu_ready, 0);
            step();
        end
        arb_ready = 1'b1;
        exp_q.push_back(64'h1111);
        #1;
        check_eq("unstall_lsu_ready", lsu_ready, 1);
        step();
        lsu_valid = 1'b0;

        // Reset while BUSY (load owns the bus): everything drops immediately
        dc_done = 1'b1; sq_valid = 1'b1; reset_n = 1'b0;
        #1;
        check_eq("midrst_arb_valid", arb_valid, 0);
        check_eq("midrst_sq_ready",  sq_ready,  0);
        check_eq("midrst_lsu_done",  lsu_done,  0);
        check_eq("midrst_sq_done",   sq_done,   0);
        step(); step();
        reset_n = 1'b1; dc_done = 1'b0;
        exp_q.push_back(64'h2222);
        #1;
        check_eq("postrst_arb_valid", arb_valid, 1);
        check_eq("postrst_sq_ready",  sq_ready,  1);
        step();
        sq_valid = 1'b0; dc_done = 1'b1;
        step();
        dc_done = 1'b0;

        // Continuous contention with done one cycle after each grant
        reset_n = 1'b0;
        #1;
        step();
        reset_n   = 1'b1;
        lsu_valid = 1'b1; sq_valid = 1'b1;
        ctr = 0;
        for (int g = 0; g < 6; g++) begin
            st = c_STARVE && (ctr == c_LIMIT);
            if (st) ctr = 0;
            else if (ctr < c_LIMIT) ctr++;
            exp_q.push_back(st ? 64'h2222 : 64'h1111);
            #1;
            check_eq("contend_lsu_ready", lsu_ready, !st);
            check_eq("contend_sq_ready",  sq_ready,  st);
            step();
            dc_done = 1'b1;
            #1;
            check_eq("contend_lsu_done", lsu_done, !st);
            check_eq("contend_sq_done",  sq_done,  st);
            step();
            dc_done = 1'b0;
        end
        lsu_valid = 1'b0; sq_valid = 1'b0;
        step();
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: number of consecutive lost arbitration cycles before the store requester is forced to win; legal range 1..255.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 lsu2arb_tbus_index_valid  input  1  load pipe requests the tbus.
REQ-005 lsu2arb_tbus_index_ready  output  1  load request accepted this cycle.
REQ-006 lsu2arb_tbus_index / _write_data / _write_mask / _operation_type  input  `RESULT_RANGE / `SRC_RANGE / 64 / `TBUS_OPTYPE_RANGE  load request payload.
REQ-007 lsu2arb_tbus_read_data / _operation_done  output  `RESULT_RANGE / 1  load response.
REQ-008 sq2arb_tbus_index_valid, _ready, _index, _write_data, _write_mask, _operation_type, _read_data, _operation_done: same directions and widths as REQ-004..007, for the store queue.
REQ-009 arb2dcache_tbus_index_valid  output  1; arb2dcache_tbus_index_ready  input  1; arb2dcache_tbus_index / _write_data / _write_mask / _operation_type  output, widths as REQ-006.
REQ-010 arb2dcache_tbus_read_data  input  `RESULT_RANGE; arb2dcache_tbus_operation_done  input  1.

Function
REQ-011 FSM states: IDLE, BUSY; a registered owner field holds NONE, LOAD or STORE.
REQ-012 IDLE, any requester valid: choose a winner combinationally; drive arb2dcache valid=1 and the winner's payload.
REQ-013 Winner: LOAD if lsu valid, else STORE; override to STORE when the starvation counter equals STARVE_LIMIT and sq valid (feature REQ-022).
REQ-014 Only the winner's ready = arb2dcache_tbus_index_ready, and only in IDLE; the loser's ready = 0.
REQ-015 Fire (IDLE & arb2dcache valid & ready): next cycle state=BUSY, owner=winner.
REQ-016 BUSY: arb2dcache valid=0 and both requester readies=0; requests are held off, not dropped.
REQ-017 read_data is broadcast unmodified to both requesters; operation_done is forwarded combinationally only to the owner.
REQ-018 BUSY & arb2dcache_tbus_operation_done: next cycle IDLE, owner=NONE; no grant in the done cycle (one bubble between operations).
REQ-019 Operation_done received while IDLE is ignored and forwarded to neither requester.
REQ-020 Payload outputs are don't-care when valid=0 but are driven with the load payload, never X.

Reset
REQ-021 Reset asserted (including mid-BUSY): state=IDLE, owner=NONE, starvation counter=0; all valid/ready/done outputs = 0 while reset_n=0; the in-flight operation is abandoned.

Configuration
REQ-022 Macro TBUS_ARB_STARVE_EN defined: the counter increments (saturating at STARVE_LIMIT) each IDLE cycle where sq valid and the store does not fire, and clears to 0 on store fire; a saturated counter forces a store win (REQ-013).
REQ-023 Macro undefined: strict load priority, no counter logic, STARVE_LIMIT unused.

Structure
REQ-024 The shared package holds the owner enum (NONE/LOAD/STORE) and the FSM state enum; `TBUS_* ranges stay in defines.sv.
REQ-025 One sub-module, tbus_starve_ctr (saturating counter with inc/clr/sat), is instantiated only under TBUS_ARB_STARVE_EN.

Verification
REQ-026 Both valid in the same cycle, dcache ready=1 -> lsu ready=1, sq ready=0, arb2dcache_index=lsu index; next cycle owner=LOAD.
REQ-027 Store grant, dcache done asserted 3 cycles later with read_data=0xDEAD -> sq done=1, lsu done=0, both read_data=0xDEAD; next grant no earlier than 1 cycle after done.
REQ-028 STARVE_EN, STARVE_LIMIT=2, lsu and sq valid every cycle, done 1 cycle after each grant -> store granted on the grant opportunity after two load grants; counter resets.
REQ-029 Macro off, same stimulus as REQ-028 -> store never granted while lsu valid.
REQ-030 reset_n pulsed low while BUSY -> outputs 0 immediately; after release IDLE, and a pending sq request is granted with dcache ready=1.
REQ-031 Dcache ready=0 for 4 cycles with lsu valid -> arb2dcache valid held at 1, lsu ready=0, state stays IDLE.
